// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: two requester ports (p, d), the memory drive and busy.
// master = requesters plus memory model side, slave = the arbiter.
interface mem_arbiter_if;
  logic        p_req;
  logic        p_we;
  logic [5:0]  p_addr;
  logic [15:0] p_wdata;
  logic        p_gnt;
  logic        p_ack;
  logic [15:0] p_rdata;

  logic        d_req;
  logic        d_we;
  logic [5:0]  d_addr;
  logic [15:0] d_wdata;
  logic        d_gnt;
  logic        d_ack;
  logic [15:0] d_rdata;

  logic [5:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_write;
  logic        mem_read;
  logic [15:0] mem_rdata;

  logic        busy;

  modport master (
    output p_req, p_we, p_addr, p_wdata,
    input  p_gnt, p_ack, p_rdata,
    output d_req, d_we, d_addr, d_wdata,
    input  d_gnt, d_ack, d_rdata,
    input  mem_addr, mem_wdata, mem_write, mem_read,
    output mem_rdata,
    input  busy
  );

  modport slave (
    input  p_req, p_we, p_addr, p_wdata,
    output p_gnt, p_ack, p_rdata,
    input  d_req, d_we, d_addr, d_wdata,
    output d_gnt, d_ack, d_rdata,
    output mem_addr, mem_wdata, mem_write, mem_read,
    input  mem_rdata,
    output busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-port synchronous-read memory; one access per 3 cycles.
// Optional `MEM_ARB_RR_EN selects round-robin arbitration; default is fixed priority to port p.
module mem_arbiter (
  input logic          clk,
  input logic          proc_rst,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StAccess = 2'b01,
    StResp   = 2'b10
  } state_e;

  state_e      state_q, state_d;
  logic        win_q, win_d;      // 0: p port, 1: d port
  logic        we_q, we_d;
  logic [5:0]  addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        ack_q, ack_d;
  logic [15:0] p_rdata_q, p_rdata_d;
  logic [15:0] d_rdata_q, d_rdata_d;
  logic        any_req;
  logic        sel;

  assign any_req = bus.p_req | bus.d_req;

`ifdef MEM_ARB_RR_EN
  logic rr_q, rr_d;               // 1: d port favoured on contention

  always_comb begin
    sel = 1'b0;
    if (bus.p_req && bus.d_req) begin
      sel = rr_q;
    end else begin
      sel = bus.d_req;
    end
    rr_d = rr_q;
    if (state_q == StIdle && any_req) begin
      rr_d = ~sel;
    end
  end

  always_ff @(posedge clk or negedge proc_rst) begin
    if (!proc_rst) begin
      rr_q <= 1'b0;
    end else begin
      rr_q <= rr_d;
    end
  end
`else
  assign sel = ~bus.p_req;
`endif

  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    ack_d     = 1'b0;
    p_rdata_d = p_rdata_q;
    d_rdata_d = d_rdata_q;
    case (state_q)
      StIdle: begin
        if (any_req) begin
          state_d = StAccess;
          win_d   = sel;
          we_d    = sel ? bus.d_we    : bus.p_we;
          addr_d  = sel ? bus.d_addr  : bus.p_addr;
          wdata_d = sel ? bus.d_wdata : bus.p_wdata;
        end
      end
      StAccess: state_d = StResp;
      StResp: begin
        state_d = StIdle;
        ack_d   = 1'b1;
        // Memory read data arrives during this cycle.
        if (!we_q) begin
          if (win_q) begin
            d_rdata_d = bus.mem_rdata;
          end else begin
            p_rdata_d = bus.mem_rdata;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge proc_rst) begin
    if (!proc_rst) begin
      state_q   <= StIdle;
      win_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= 6'h00;
      wdata_q   <= 16'h0000;
      ack_q     <= 1'b0;
      p_rdata_q <= 16'h0000;
      d_rdata_q <= 16'h0000;
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      ack_q     <= ack_d;
      p_rdata_q <= p_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  // Latched address/data double as the memory drive, so they hold outside ACCESS.
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_write = (state_q == StAccess) &  we_q;
  assign bus.mem_read  = (state_q == StAccess) & ~we_q;
  assign bus.p_gnt     = (state_q == StAccess) & ~win_q;
  assign bus.d_gnt     = (state_q == StAccess) &  win_q;
  assign bus.p_ack     = ack_q & ~win_q;
  assign bus.d_ack     = ack_q &  win_q;
  assign bus.p_rdata   = p_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.busy      = (state_q != StIdle);

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The module SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 The module SHALL have port proc_rst, input, 1 bit: reset, asynchronous, active-low.
REQ-003 The module SHALL have ports p_req, p_we, p_addr, p_wdata, inputs of 1, 1, 6 and 16 bits: processor port request, write select, word address and write data.
REQ-004 The module SHALL have ports p_gnt and p_ack, outputs, 1 bit each: processor port grant pulse and completion pulse.
REQ-005 The module SHALL have port p_rdata, output, 16 bits: processor port read data.
REQ-006 The module SHALL have ports d_req, d_we, d_addr, d_wdata, d_gnt, d_ack and d_rdata: loader/debug port, with the same widths and meanings as the p_* ports.
REQ-007 The module SHALL have ports mem_addr, mem_wdata, mem_write and mem_read, outputs of 6, 16, 1 and 1 bits: drive to the single-port memory.
REQ-008 The module SHALL have port mem_rdata, input, 16 bits: memory read data, valid one cycle after the cycle in which mem_read is high (synchronous read).
REQ-009 The module SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-010 The FSM SHALL have states IDLE, ACCESS and RESP, encoded in 2 bits; the spare encoding SHALL return to IDLE.
REQ-011 In IDLE, at a clock edge with at least one req high, the arbiter SHALL select a winner, latch its we/addr/wdata, go to ACCESS and assert the winner's gnt during the ACCESS cycle only.
REQ-012 In IDLE with no req high, the FSM SHALL stay in IDLE and all gnt, ack, mem_write and mem_read SHALL be 0.
REQ-013 In ACCESS, mem_addr and mem_wdata SHALL come from the latched values; mem_write SHALL equal the latched we and mem_read SHALL equal its inverse; the next state SHALL be RESP.
REQ-014 In RESP, mem_write and mem_read SHALL be 0; at the end of RESP, a read SHALL load mem_rdata into the winner's rdata register; the next state SHALL be IDLE.
REQ-015 The winner's ack SHALL pulse for exactly one cycle, the first IDLE cycle after RESP, for both reads and writes.
REQ-016 Latency SHALL be fixed: req sampled at edge N, gnt in cycle N+1, memory access in cycle N+1, ack and valid rdata in cycle N+3; maximum throughput SHALL be one transaction per 3 cycles.
REQ-017 Each x_rdata SHALL hold its value until that port's next read completes; the loser's rdata and ack SHALL be unaffected.
REQ-018 A requester SHALL hold req, we, addr and wdata stable until gnt; a req still high in the ack cycle SHALL be treated as a new request sampled at the end of that cycle.
REQ-019 A req deasserted before being sampled in IDLE SHALL produce no gnt, no memory access and no ack.
REQ-020 req inputs SHALL be ignored in ACCESS and RESP.
REQ-021 When outside ACCESS, mem_addr and mem_wdata SHALL hold their last driven values.

Reset
REQ-022 Asserting proc_rst low SHALL immediately force state IDLE, all gnt/ack/mem_write/mem_read/busy to 0, p_rdata and d_rdata to 16'h0000, mem_addr to 6'h00, mem_wdata to 16'h0000 and the round-robin pointer to favour the p port.
REQ-023 Reset asserted during ACCESS or RESP SHALL abort the transaction with no ack; normal operation SHALL resume on the first rising edge after proc_rst returns high.

Configuration
REQ-024 With MEM_ARB_RR_EN defined, simultaneous requests SHALL be granted round-robin: the port not granted last wins, and the pointer updates on every grant.
REQ-025 Without MEM_ARB_RR_EN, simultaneous requests SHALL always be granted to the p port (fixed priority), and no pointer register SHALL exist.

Verification
REQ-026 Single read: memory word 6'h05 holds 16'hBEEF; p_req=1, p_we=0, p_addr=6'h05 at edge 0 -> p_gnt in cycle 1, mem_read=1 with mem_addr=6'h05 in cycle 1, p_ack and p_rdata=16'hBEEF in cycle 3.
REQ-027 Write then read: d port writes 16'h1234 to 6'h3F, then reads 6'h3F -> mem_write only in the first ACCESS cycle, d_ack twice, d_rdata=16'h1234, p_ack never asserted.
REQ-028 Contention with MEM_ARB_RR_EN: p_req and d_req held high for 4 transactions -> grant order p, d, p, d; without the macro -> p, p, p, p.
REQ-029 Reset mid-operation: proc_rst low during the ACCESS cycle of a d-port write -> mem_write drops in the same cycle, no d_ack, busy=0, both rdata=16'h0000.
REQ-030 Withdrawn request and back-to-back: p_req pulses low before any sampled edge -> no activity; p_req held high through its ack cycle -> second p_gnt exactly 3 cycles after the first.
